regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register width in bits.
REQ-002 SHALL have parameter NUM_REGISTER, default 32, meaning register count (power of two, >=2); AW = $clog2(NUM_REGISTER).
REQ-003 SHALL have parameter NUM_READ, default 2, meaning number of read ports (1..4).
REQ-004 SHALL have parameter NUM_WRITE, default 2, meaning number of write ports (1..2).
REQ-005 SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write data forwarded to reads, 0 = reads return stored value.
REQ-006 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-007 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port flush_i  input  1  clears all scoreboard busy bits.
REQ-009 SHALL have port we_i  input  NUM_WRITE  per-port write enable.
REQ-010 SHALL have port rd_addr_i  input  NUM_WRITE*AW  per-port write address, port k at bits [k*AW +: AW].
REQ-011 SHALL have port rd_data_i  input  NUM_WRITE*DATA_WIDTH  per-port write data.
REQ-012 SHALL have port rs_addr_i  input  NUM_READ*AW  per-port read address.
REQ-013 SHALL have port rs_data_o  output  NUM_READ*DATA_WIDTH  per-port read data.
REQ-014 SHALL have port rs_busy_o  output  NUM_READ  per-port "operand pending" flag.
REQ-015 SHALL have port iss_valid_i  input  1  issue strobe; marks iss_rd_i pending.
REQ-016 SHALL have port iss_rd_i  input  AW  destination register of issued instruction.
REQ-017 SHALL have port busy_o  output  NUM_REGISTER  full scoreboard vector, bit i = register i pending.

Function
REQ-018 SHALL store NUM_REGISTER words; register 0 SHALL always read 0 and ignore writes and issues.
REQ-019 SHALL commit write port k on rising edge when we_i[k]=1 and address != 0.
REQ-020 SHALL, when two write ports target the same nonzero address in one cycle, commit the higher-indexed port's data.
REQ-021 SHALL drive rs_data_o combinationally; BYPASS=1: if any enabled write port targets the read address (nonzero), output that write data (REQ-020 priority), else stored value; BYPASS=0: stored value only.
REQ-022 SHALL keep one busy bit per register; busy[0] SHALL be constant 0.
REQ-023 SHALL set busy[iss_rd_i] on rising edge when iss_valid_i=1 and iss_rd_i != 0.
REQ-024 SHALL clear busy[a] on rising edge when any write port commits to address a.
REQ-025 SHALL, on simultaneous issue and write to the same register, leave busy set (issue wins; write data still committed).
REQ-026 SHALL, on flush_i=1, clear all busy bits at the next edge; an issue in the same cycle SHALL still set its bit (issue wins over flush); register data unaffected.
REQ-027 SHALL drive busy_o directly from the busy state (no combinational path from inputs).
REQ-028 SHALL drive rs_busy_o[p] = busy[addr_p] AND NOT (BYPASS=1 AND an enabled write port targets addr_p this cycle).
REQ-029 SHALL have read latency 0 cycles, write-to-storage latency 1 cycle, issue-to-busy latency 1 cycle.

Reset
REQ-030 SHALL, while rst_n_i=0, asynchronously clear all registers to 0 and all busy bits to 0, so rs_data_o=0 (absent bypass), rs_busy_o=0, busy_o=0.
REQ-031 SHALL ignore writes, issues and flush while rst_n_i=0 and resume normal operation on the first rising edge after deassertion.
REQ-032 SHALL, on reset asserted mid-operation, discard all in-flight busy state and data without an intervening clock.

Verification
REQ-033 SHALL test: write port0 x5=0xDEADBEEF, next cycle read rs0=x5 -> rs_data_o port0 = 0xDEADBEEF; write x0=0x1234 -> x0 reads 0.
REQ-034 SHALL test: BYPASS=1, same cycle we port0 x7=0xA5A5A5A5 and read x7 -> output 0xA5A5A5A5, rs_busy_o 0; BYPASS=0 -> output previous value 0.
REQ-035 SHALL test: both ports write x3 (port0 0x11, port1 0x22) -> x3 = 0x22 next cycle.
REQ-036 SHALL test: issue x9 -> busy_o[9]=1 next cycle; write x9=0x55 -> busy_o[9]=0 next cycle; simultaneous issue x9 + write x9 -> busy_o[9] stays 1, x9=0x55.
REQ-037 SHALL test: issue x4, x6 over two cycles then flush with issue x8 -> busy_o = only bit 8 set; register data unchanged.
REQ-038 SHALL test: reset asserted asynchronously between edges with busy and data nonzero -> busy_o=0 and all reads 0 immediately.

Source files
------------

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- multi-ported register file with an issue scoreboard.
//
// Holds NUM_REGISTER words of DATA_WIDTH bits. Register 0 is hard-wired to
// zero. Each register also has a "busy" bit. An issued instruction marks its
// destination as pending, and a later write to that register clears the mark.
//
// Ports
//   clk_i        rising-edge clock for all state
//   rst_n_i      asynchronous active-low reset (clears data and busy bits)
//   flush_i      clears every busy bit at the next edge
//   we_i         per write port enable
//   rd_addr_i    per write port address, port k at [k*AW +: AW]
//   rd_data_i    per write port data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rs_addr_i    per read port address
//   rs_data_o    per read port data (combinational, optional write bypass)
//   rs_busy_o    per read port "operand pending" flag
//   iss_valid_i  issue strobe
//   iss_rd_i     destination register of the issued instruction
//   busy_o       full scoreboard vector, driven straight from state
// ---------------------------------------------------------------------------
module regfile_mp #(
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_REGISTER = 32,
   parameter int NUM_READ     = 2,
   parameter int NUM_WRITE    = 2,
   parameter int BYPASS       = 1,
   localparam int AW          = $clog2(NUM_REGISTER)
) (
   input  logic                             clk_i,
   input  logic                             rst_n_i,
   input  logic                             flush_i,
   input  logic [NUM_WRITE-1:0]             we_i,
   input  logic [NUM_WRITE*AW-1:0]          rd_addr_i,
   input  logic [NUM_WRITE*DATA_WIDTH-1:0]  rd_data_i,
   input  logic [NUM_READ*AW-1:0]           rs_addr_i,
   output logic [NUM_READ*DATA_WIDTH-1:0]   rs_data_o,
   output logic [NUM_READ-1:0]              rs_busy_o,
   input  logic                             iss_valid_i,
   input  logic [AW-1:0]                    iss_rd_i,
   output logic [NUM_REGISTER-1:0]          busy_o
);

   logic [DATA_WIDTH-1:0]   mem_q [NUM_REGISTER];
   logic [DATA_WIDTH-1:0]   mem_d [NUM_REGISTER];
   logic [NUM_REGISTER-1:0] busy_q;
   logic [NUM_REGISTER-1:0] busy_d;

   // True when write port k commits to address a this cycle. Writes to
   // register 0 never count as a commit.
   function automatic logic wr_match(input int k, input logic [AW-1:0] a);
      return we_i[k] && (rd_addr_i[k*AW +: AW] == a) && (a != {AW{1'b0}});
   endfunction

   // Next register contents. Ports are scanned in ascending order, so the
   // highest-indexed port that targets a register provides its data.
   always_comb begin
      mem_d = mem_q;
      for (int i = 1; i < NUM_REGISTER; i++) begin
         for (int k = 0; k < NUM_WRITE; k++) begin
            mem_d[i] = wr_match(k, AW'(i)) ? rd_data_i[k*DATA_WIDTH +: DATA_WIDTH]
                                           : mem_d[i];
         end
      end
      mem_d[0] = {DATA_WIDTH{1'b0}};
   end

   // Next scoreboard. A flush or a commit clears a bit. An issue is applied
   // last, so it wins over both.
   always_comb begin
      busy_d = flush_i ? {NUM_REGISTER{1'b0}} : busy_q;
      for (int i = 1; i < NUM_REGISTER; i++) begin
         for (int k = 0; k < NUM_WRITE; k++) begin
            busy_d[i] = wr_match(k, AW'(i)) ? 1'b0 : busy_d[i];
         end
         busy_d[i] = (iss_valid_i && (iss_rd_i == AW'(i))) ? 1'b1 : busy_d[i];
      end
      busy_d[0] = 1'b0;
   end

   // State registers. The async reset discards data and pending marks
   // immediately, without waiting for a clock edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         busy_q <= {NUM_REGISTER{1'b0}};
         for (int i = 0; i < NUM_REGISTER; i++) begin
            mem_q[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         busy_q <= busy_d;
         mem_q  <= mem_d;
      end
   end

   // Read ports. Stored value and busy bit are used first, and the bypass
   // then overrides them with same-cycle write data. An operand being
   // written this cycle is no longer pending.
   always_comb begin
      rs_data_o = {(NUM_READ*DATA_WIDTH){1'b0}};
      rs_busy_o = {NUM_READ{1'b0}};
      for (int p = 0; p < NUM_READ; p++) begin
         rs_data_o[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[rs_addr_i[p*AW +: AW]];
         rs_busy_o[p] = busy_q[rs_addr_i[p*AW +: AW]];
         for (int k = 0; k < NUM_WRITE; k++) begin
            rs_data_o[p*DATA_WIDTH +: DATA_WIDTH] =
               ((BYPASS != 0) && wr_match(k, rs_addr_i[p*AW +: AW]))
                  ? rd_data_i[k*DATA_WIDTH +: DATA_WIDTH]
                  : rs_data_o[p*DATA_WIDTH +: DATA_WIDTH];
            rs_busy_o[p] =
               ((BYPASS != 0) && wr_match(k, rs_addr_i[p*AW +: AW]))
                  ? 1'b0 : rs_busy_o[p];
         end
      end
   end

   assign busy_o = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp -- self-checking bench for regfile_mp.
// Two instances share every input. One is built with BYPASS=1 and the other
// with BYPASS=0. A behavioural model (an array of words plus a pending-bit
// vector) predicts the outputs of both instances. The outputs are compared at
// every falling edge. Directed steps add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_regfile_mp;
   localparam int DW  = 32;
   localparam int NR  = 32;
   localparam int NRD = 2;
   localparam int NWR = 2;
   localparam int AW  = 5;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b0;
   logic             flush     = 1'b0;
   logic             iss_valid = 1'b0;
   logic [AW-1:0]    iss_rd    = '0;
   logic [NWR-1:0]   we        = '0;
   logic [NWR*AW-1:0] wa       = '0;
   logic [NWR*DW-1:0] wd       = '0;
   logic [NRD*AW-1:0] ra       = '0;

   logic [NRD*DW-1:0] rs_data_b, rs_data_n;
   logic [NRD-1:0]    rs_busy_b, rs_busy_n;
   logic [NR-1:0]     busy_b, busy_n;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   logic [DW-1:0] m_reg [NR];
   logic [NR-1:0] m_busy;

   always #5 clk = ~clk;

   regfile_mp #(.DATA_WIDTH(DW), .NUM_REGISTER(NR), .NUM_READ(NRD),
                .NUM_WRITE(NWR), .BYPASS(1)) u_byp (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .we_i(we),
      .rd_addr_i(wa), .rd_data_i(wd), .rs_addr_i(ra), .rs_data_o(rs_data_b),
      .rs_busy_o(rs_busy_b), .iss_valid_i(iss_valid), .iss_rd_i(iss_rd),
      .busy_o(busy_b));

   regfile_mp #(.DATA_WIDTH(DW), .NUM_REGISTER(NR), .NUM_READ(NRD),
                .NUM_WRITE(NWR), .BYPASS(0)) u_nob (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .we_i(we),
      .rd_addr_i(wa), .rd_data_i(wd), .rs_addr_i(ra), .rs_data_o(rs_data_n),
      .rs_busy_o(rs_busy_n), .iss_valid_i(iss_valid), .iss_rd_i(iss_rd),
      .busy_o(busy_n));

   // ---------------- behavioural model ----------------
   function automatic bit port_hits(int k, int a);
      return (a != 0) && we[k] && (wa[k*AW +: AW] == AW'(a));
   endfunction

   function automatic logic [DW-1:0] exp_data(int a, bit byp);
      logic [DW-1:0] v;
      v = m_reg[a];
      if (byp) begin
         for (int k = 0; k < NWR; k++)
            if (port_hits(k, a)) v = wd[k*DW +: DW];
      end
      return v;
   endfunction

   function automatic bit exp_rbusy(int a, bit byp);
      bit b;
      b = m_busy[a];
      if (byp) begin
         for (int k = 0; k < NWR; k++)
            if (port_hits(k, a)) b = 1'b0;
      end
      return b;
   endfunction

   function automatic logic [NR-1:0] next_busy();
      logic [NR-1:0] b;
      b = flush ? '0 : m_busy;
      for (int i = 0; i < NR; i++)
         for (int k = 0; k < NWR; k++)
            if (port_hits(k, i)) b[i] = 1'b0;
      if (iss_valid && iss_rd != '0) b[iss_rd] = 1'b1;
      return b;
   endfunction

   // Model state update: reset is asynchronous, and a later port's NBA wins.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NR; i++) m_reg[i] <= '0;
         m_busy <= '0;
      end else begin
         for (int i = 1; i < NR; i++)
            for (int k = 0; k < NWR; k++)
               if (port_hits(k, i)) m_reg[i] <= wd[k*DW +: DW];
         m_busy <= next_busy();
      end
   end

   // ---------------- comparison helpers ----------------
   task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_all();
      for (int p = 0; p < NRD; p++) begin
         int a;
         a = int'(ra[p*AW +: AW]);
         cmp($sformatf("byp rs_data[%0d] x%0d", p, a), rs_data_b[p*DW +: DW], exp_data(a, 1'b1));
         cmp($sformatf("nob rs_data[%0d] x%0d", p, a), rs_data_n[p*DW +: DW], exp_data(a, 1'b0));
         cmp($sformatf("byp rs_busy[%0d] x%0d", p, a), rs_busy_b[p], exp_rbusy(a, 1'b1));
         cmp($sformatf("nob rs_busy[%0d] x%0d", p, a), rs_busy_n[p], exp_rbusy(a, 1'b0));
      end
      cmp("byp busy_o", busy_b, m_busy);
      cmp("nob busy_o", busy_n, m_busy);
   endtask

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) check_all();
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
      we = '0; iss_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic wr(int k, int a, logic [DW-1:0] d);
      we[k] = 1'b1;
      wa[k*AW +: AW] = AW'(a);
      wd[k*DW +: DW] = d;
   endtask

   task automatic rd(int p, int a);
      ra[p*AW +: AW] = AW'(a);
   endtask

   task automatic iss(int a);
      iss_valid = 1'b1;
      iss_rd = AW'(a);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      cmp("reset busy_o", busy_b, 64'h0);
      cmp("reset rs_data", rs_data_n, 64'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Write x5 with the bypass exercised in the same cycle, then read it back.
      step(); wr(0, 5, 32'hDEADBEEF); rd(0, 5);
      @(negedge clk);
      cmp("lit bypass x5", rs_data_b[31:0], 64'hDEADBEEF);
      cmp("lit nobypass x5 old", rs_data_n[31:0], 64'h0);
      step(); rd(0, 5); wr(0, 0, 32'h1234); rd(1, 0);
      @(negedge clk);
      cmp("lit x5 stored byp", rs_data_b[31:0], 64'hDEADBEEF);
      cmp("lit x5 stored nob", rs_data_n[31:0], 64'hDEADBEEF);
      cmp("lit x0 no bypass", rs_data_b[63:32], 64'h0);
      step(); rd(1, 0);
      @(negedge clk);
      cmp("lit x0 after write", rs_data_n[63:32], 64'h0);

      // Bypass versus stored value on x7, with x7 pending.
      step(); iss(7);
      step(); wr(0, 7, 32'hA5A5A5A5); rd(0, 7);
      @(negedge clk);
      cmp("lit bypass x7 data", rs_data_b[31:0], 64'hA5A5A5A5);
      cmp("lit bypass x7 busy", rs_busy_b[0], 64'h0);
      cmp("lit nobypass x7 data", rs_data_n[31:0], 64'h0);
      cmp("lit nobypass x7 busy", rs_busy_n[0], 64'h1);

      // Two ports writing x3: port 1 wins.
      step(); wr(0, 3, 32'h11); wr(1, 3, 32'h22); rd(1, 3);
      @(negedge clk);
      cmp("lit bypass x3 prio", rs_data_b[63:32], 64'h22);
      step(); rd(1, 3); rd(0, 7);
      @(negedge clk);
      cmp("lit x3 stored", rs_data_n[63:32], 64'h22);
      cmp("lit x7 stored", rs_data_n[31:0], 64'hA5A5A5A5);
      cmp("lit x7 busy cleared", busy_b[7], 64'h0);

      // Scoreboard on x9: issue, then clear, then issue together with a write.
      step(); iss(9);
      step(); wr(0, 9, 32'h33);
      @(negedge clk);
      cmp("lit x9 busy after issue", busy_b[9], 64'h1);
      step(); iss(9); wr(1, 9, 32'h55);
      @(negedge clk);
      cmp("lit x9 busy after write", busy_n[9], 64'h0);
      step(); rd(0, 9);
      @(negedge clk);
      cmp("lit x9 issue wins", busy_b[9], 64'h1);
      cmp("lit x9 data committed", rs_data_n[31:0], 64'h55);

      // Flush with an issue in the same cycle.
      step(); iss(4);
      step(); iss(6);
      step(); flush = 1'b1; iss(8);
      step(); rd(0, 5); rd(1, 3);
      @(negedge clk);
      cmp("lit flush busy_o", busy_b, 64'h100);
      cmp("lit flush x5 kept", rs_data_n[31:0], 64'hDEADBEEF);
      cmp("lit flush x3 kept", rs_data_n[63:32], 64'h22);

      // Asynchronous reset between edges.
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      cmp("lit async rst busy_o", busy_b, 64'h0);
      cmp("lit async rst rs_data byp", rs_data_b, 64'h0);
      cmp("lit async rst rs_data nob", rs_data_n, 64'h0);
      repeat (2) step();
      rst_n = 1'b1;

      // Randomized traffic. Half of the addresses are kept in a small range so
      // that port collisions and read-after-write cases occur often.
      for (int i = 0; i < 3000; i++) begin
         step();
         if (i == 1503) rst_n = 1'b1;
         for (int k = 0; k < NWR; k++) begin
            we[k] = ($urandom_range(0, 2) != 0);
            wa[k*AW +: AW] = AW'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            wd[k*DW +: DW] = $urandom;
         end
         for (int p = 0; p < NRD; p++)
            ra[p*AW +: AW] = AW'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31));
         iss_valid = ($urandom_range(0, 1) != 0);
         iss_rd = AW'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31));
         flush = ($urandom_range(0, 15) == 0);
         if (i == 1500) begin
            #2;
            rst_n = 1'b0;
         end
      end

      step();
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
